reset_seq_ctrl: RTL and testbench
=================================

# reset_seq_ctrl

Reset-release sequencer sitting downstream of the POR/reset-pad block in the Caravel/FSIC reset tree. It consumes the synchronized board reset `rstb_h` and releases `N_DOM` downstream domain resets one at a time, in index order. Each release is preceded by a programmable hold interval, and the next domain is not started until the current domain acknowledges ready. A level software-reset request re-asserts all domain resets and restarts the sequence.

## Interface

- `N_DOM`, 3: number of sequenced reset domains (1..8).
- `HOLD_CYC`, 8: clk cycles spent in HOLD before each domain release (≥1).
- `WDT_W`, 16: ready-watchdog counter width; used only with `RST_SEQ_WDT_EN`.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rstb_h`  in  1  reset: asynchronous, active-low, sourced by the POR/reset-pad block.
- `sw_rst_req`  in  1  software reset request, level, synchronous to `clk`.
- `dom_ready`  in  N_DOM  per-domain ready acknowledge, synchronous to `clk`.
- `dom_rstb`  out  N_DOM  per-domain reset, active-low, registered.
- `seq_done`  out  1  all domains released and acknowledged, registered.
- `seq_err`  out  1  sticky watchdog-timeout flag, registered.
- `cur_dom`  out  3  index of the domain currently being sequenced, registered.

## Operation

- **States:** RESET, HOLD, WAIT_RDY, DONE. Internal registers: `idx` (3b), `cnt` (hold counter), `wdt` (WDT_W bits, only with `RST_SEQ_WDT_EN`).
- **While `rstb_h`=0:** state=RESET, `dom_rstb`=0, `seq_done`=0, `seq_err`=0, `cur_dom`=0, `idx`=0, `cnt`=0, `wdt`=0.
- **RESET:**
  - All `dom_rstb`=0.
  - Stay in RESET while `sw_rst_req`=1.
  - Otherwise go to HOLD with `cnt`=0.
- **HOLD:**
  - `cnt` increments each cycle.
  - On the edge where `cnt`==HOLD_CYC-1: set `dom_rstb[idx]`=1, clear `wdt`, go to WAIT_RDY.
- **WAIT_RDY:**
  - If `dom_ready[idx]`=1 is sampled and `idx`==N_DOM-1: go to DONE and set `seq_done`=1.
  - If `dom_ready[idx]`=1 is sampled and `idx`<N_DOM-1: increment `idx`, set `cnt`=0, go to HOLD.
  - Only `dom_ready[idx]` is observed. Other ready bits are ignored.
- **DONE:** hold all outputs.
- **`sw_rst_req` priority:** `sw_rst_req`=1 in HOLD, WAIT_RDY or DONE takes priority over every other transition. On the next edge: state=RESET, `dom_rstb`=0, `seq_done`=0, `idx`=0, `cnt`=0. `seq_err` is not cleared.
- **Release order:** domains already released keep `dom_rstb`=1 while later domains sequence. A deasserting `dom_ready` after acknowledge has no effect.
- **`cur_dom`:** mirrors `idx`.

## Timing

- Edge 1 is the first rising `clk` edge with `rstb_h`=1. At edge 1, RESET→HOLD.
- `dom_rstb[0]` rises at edge 1+HOLD_CYC.
- With `dom_ready` already high, `dom_rstb[k]` rises at edge 1+HOLD_CYC+k·(HOLD_CYC+1).
- `seq_done` rises 1 cycle after `dom_ready[N_DOM-1]` is sampled in WAIT_RDY.
- A `sw_rst_req` pulse of 1 cycle forces all `dom_rstb` low at the next edge. Re-release of domain 0 starts HOLD_CYC+1 edges after `sw_rst_req` falls.
- An asynchronous `rstb_h` fall resets everything immediately, including mid-HOLD or mid-WAIT_RDY. No output glitches high.

## Configuration

- **`RST_SEQ_WDT_EN` defined:**
  - In WAIT_RDY, `wdt` increments each cycle while `dom_ready[idx]`=0.
  - When `wdt` reaches 2^WDT_W−1 with ready still low, `seq_err` is set to 1 (sticky until `rstb_h`=0), and the FSM advances exactly as if ready had been sampled.
- **Not defined:**
  - No `wdt` register; WAIT_RDY waits indefinitely.
  - `seq_err` is tied 0.

## Test plan

- N_DOM=3, HOLD_CYC=8, `dom_ready` tied 3'b111, release `rstb_h` → `dom_rstb` 001 at edge 9, 011 at edge 18, 111 at edge 27; `seq_done`=1 at edge 28.
- `dom_ready[1]` held 0 for 50 cycles after `dom_rstb[1]` rises → `dom_rstb[2]` stays 0 and `cur_dom`=1 throughout; `dom_rstb[2]` rises 9 edges after `dom_ready[1]` rises.
- In DONE, 1-cycle `sw_rst_req` → `dom_rstb`=000 and `seq_done`=0 next edge; full sequence repeats with the same spacing.
- `rstb_h` pulled low while in WAIT_RDY for domain 1 → all outputs 0 asynchronously; sequence restarts from domain 0 after release.
- With `RST_SEQ_WDT_EN`, WDT_W=4, `dom_ready[0]`=0 → `seq_err`=1 and HOLD for domain 1 begins 15 cycles after `dom_rstb[0]` rises; `seq_err` survives `sw_rst_req`.
- Without the macro, same stimulus → FSM stays in WAIT_RDY; `seq_err`=0 indefinitely.

Source files
------------

// File: rtl/reset_seq_ctrl.sv
// Purpose : reset-release sequencer; releases N_DOM domain resets one at a time, in index order, after a hold interval each.
// Latency : dom_rstb[k] rises at edge 1+HOLD_CYC+k*(HOLD_CYC+1) when ready is already high; seq_done is 1 cycle after the last ready.
// Backpr. : the next domain waits for dom_ready[idx]; sw_rst_req (level) overrides everything and restarts the sequence.
//
// Ports: clk, rstb_h (async active-low board reset), sw_rst_req (sync level restart),
//        dom_ready[N_DOM] (per-domain ack), dom_rstb[N_DOM] (per-domain active-low reset),
//        seq_done, seq_err (sticky watchdog timeout), cur_dom (domain being sequenced).
// Optional feature: define RST_SEQ_WDT_EN to enable the ready watchdog (WDT_W bits).
module reset_seq_ctrl #(
    parameter int N_DOM    = 3,
    parameter int HOLD_CYC = 8,
    parameter int WDT_W    = 16
) (
    input  logic             clk,
    input  logic             rstb_h,
    input  logic             sw_rst_req,
    input  logic [N_DOM-1:0] dom_ready,
    output logic [N_DOM-1:0] dom_rstb,
    output logic             seq_done,
    output logic             seq_err,
    output logic [2:0]       cur_dom
);

    localparam logic [1:0] S_RESET    = 2'd0;
    localparam logic [1:0] S_HOLD     = 2'd1;
    localparam logic [1:0] S_WAIT_RDY = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam int              CNT_W     = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(N_DOM - 1);

    logic [1:0]       r_state;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [N_DOM-1:0] r_dom_rstb;
    logic             r_seq_done;

    logic             w_rdy_cur;   // dom_ready of the domain being sequenced
    logic [N_DOM-1:0] w_idx_oh;    // one-hot of r_idx, used to release a single domain
    logic             w_adv;       // leave WAIT_RDY this cycle

    // Index decode done with a compare loop so a 3-bit index never selects past N_DOM.
    always_comb begin
        w_rdy_cur = 1'b0;
        w_idx_oh  = '0;
        for (int i = 0; i < N_DOM; i++) begin
            if (r_idx == 3'(i)) begin
                w_rdy_cur   = dom_ready[i];
                w_idx_oh[i] = 1'b1;
            end
        end
    end

`ifdef RST_SEQ_WDT_EN
    // Timeout fires on the increment that brings the watchdog to all-ones.
    localparam logic [WDT_W-1:0] WDT_PRE = ~WDT_W'(1);

    logic [WDT_W-1:0] r_wdt;
    logic             r_seq_err;
    logic             w_wdt_to;

    assign w_wdt_to = !w_rdy_cur && (r_wdt == WDT_PRE);
    assign w_adv    = w_rdy_cur || w_wdt_to;
    assign seq_err  = r_seq_err;
`else
    assign w_adv    = w_rdy_cur;
    assign seq_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstb_h) begin
        if (!rstb_h) begin
            r_state    <= S_RESET;
            r_idx      <= 3'd0;
            r_cnt      <= '0;
            r_dom_rstb <= '0;
            r_seq_done <= 1'b0;
`ifdef RST_SEQ_WDT_EN
            r_wdt      <= '0;
            r_seq_err  <= 1'b0;
`endif
        end else if (sw_rst_req) begin
            // Software restart wins in every state; the error flag is deliberately kept.
            r_state    <= S_RESET;
            r_idx      <= 3'd0;
            r_cnt      <= '0;
            r_dom_rstb <= '0;
            r_seq_done <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state <= S_HOLD;
                    r_cnt   <= '0;
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        // Earlier domains stay released; only the current bit is added.
                        r_dom_rstb <= r_dom_rstb | w_idx_oh;
                        r_state    <= S_WAIT_RDY;
`ifdef RST_SEQ_WDT_EN
                        r_wdt      <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_RDY: begin
`ifdef RST_SEQ_WDT_EN
                    if (!w_rdy_cur) begin
                        r_wdt <= r_wdt + WDT_W'(1);
                    end
                    if (w_wdt_to) begin
                        r_seq_err <= 1'b1;
                    end
`endif
                    if (w_adv) begin
                        if (r_idx == LAST_IDX) begin
                            r_state    <= S_DONE;
                            r_seq_done <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_cnt   <= '0;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_RESET;
                end
            endcase
        end
    end

    assign dom_rstb = r_dom_rstb;
    assign seq_done = r_seq_done;
    assign cur_dom  = r_idx;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
module tb_reset_seq_ctrl;

    localparam int N_DOM    = 3;
    localparam int HOLD_CYC = 8;
`ifdef RST_SEQ_WDT_EN
    localparam int WDT_W    = 4;
    localparam int WAIT_LEN = 10;
`else
    localparam int WDT_W    = 16;
    localparam int WAIT_LEN = 50;
`endif

    logic       clk = 1'b0;
    logic       rstb_h;
    logic       sw_rst_req;
    logic [2:0] dom_ready;
    logic [2:0] dom_rstb;
    logic       seq_done;
    logic       seq_err;
    logic [2:0] cur_dom;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    reset_seq_ctrl #(
        .N_DOM    (N_DOM),
        .HOLD_CYC (HOLD_CYC),
        .WDT_W    (WDT_W)
    ) dut (
        .clk        (clk),
        .rstb_h     (rstb_h),
        .sw_rst_req (sw_rst_req),
        .dom_ready  (dom_ready),
        .dom_rstb   (dom_rstb),
        .seq_done   (seq_done),
        .seq_err    (seq_err),
        .cur_dom    (cur_dom)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ed;
        logic [2:0] ready;
        logic [2:0] rstb;
        logic       done;
        logic [2:0] cur;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%b expected=%b", name, edge_n, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] rs, input logic dn,
                             input logic [2:0] cu, input logic er);
        chk({name, ".dom_rstb"}, dom_rstb, rs);
        chk({name, ".seq_done"}, {2'b00, seq_done}, {2'b00, dn});
        chk({name, ".cur_dom"},  cur_dom, cu);
        chk({name, ".seq_err"},  {2'b00, seq_err}, {2'b00, er});
    endtask

    task automatic advance_to(input int target);
        while (edge_n < target) tick();
    endtask

    // Table edge k is relative to base: edge base+1 is the RESET->HOLD edge.
    task automatic run_table(input string name, input int base);
        for (int i = 0; i < 11; i++) begin
            dom_ready = tbl[i].ready;
            advance_to(base + tbl[i].ed);
            chk({name, ".rstb"}, dom_rstb, tbl[i].rstb);
            chk({name, ".done"}, {2'b00, seq_done}, {2'b00, tbl[i].done});
            chk({name, ".cur"},  cur_dom, tbl[i].cur);
        end
    endtask

    task automatic sw_pulse();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
    endtask

    initial begin
        int base;
        // Full sequence with all readies high: releases at 9, 18, 27; done at 28.
        tbl[0]  = '{ed: 1,  ready: 3'b111, rstb: 3'b000, done: 1'b0, cur: 3'd0};
        tbl[1]  = '{ed: 8,  ready: 3'b111, rstb: 3'b000, done: 1'b0, cur: 3'd0};
        tbl[2]  = '{ed: 9,  ready: 3'b111, rstb: 3'b001, done: 1'b0, cur: 3'd0};
        tbl[3]  = '{ed: 10, ready: 3'b111, rstb: 3'b001, done: 1'b0, cur: 3'd1};
        tbl[4]  = '{ed: 17, ready: 3'b111, rstb: 3'b001, done: 1'b0, cur: 3'd1};
        tbl[5]  = '{ed: 18, ready: 3'b111, rstb: 3'b011, done: 1'b0, cur: 3'd1};
        tbl[6]  = '{ed: 19, ready: 3'b111, rstb: 3'b011, done: 1'b0, cur: 3'd2};
        tbl[7]  = '{ed: 26, ready: 3'b111, rstb: 3'b011, done: 1'b0, cur: 3'd2};
        tbl[8]  = '{ed: 27, ready: 3'b111, rstb: 3'b111, done: 1'b0, cur: 3'd2};
        tbl[9]  = '{ed: 28, ready: 3'b111, rstb: 3'b111, done: 1'b1, cur: 3'd2};
        tbl[10] = '{ed: 31, ready: 3'b111, rstb: 3'b111, done: 1'b1, cur: 3'd2};

        rstb_h     = 1'b0;
        sw_rst_req = 1'b0;
        dom_ready  = 3'b111;

        // Reset state.
        repeat (3) tick();
        check_all("reset", 3'b000, 1'b0, 3'd0, 1'b0);

        // Nominal release sequence.
        @(negedge clk);
        rstb_h = 1'b1;
        edge_n = 0;
        run_table("seq1", 0);

        // Software restart from DONE: outputs drop next edge, sequence repeats.
        sw_pulse();
        base = edge_n;
        check_all("swrst", 3'b000, 1'b0, 3'd0, 1'b0);
        run_table("seq2", base);

        // Domain 1 stalls; other ready bits (and dropping ready[0]) are ignored.
        dom_ready = 3'b101;
        sw_pulse();
        base = edge_n;
        advance_to(base + 18);
        check_all("stall.rel1", 3'b011, 1'b0, 3'd1, 1'b0);
        dom_ready = 3'b100;
        for (int n = 0; n < WAIT_LEN; n++) begin
            tick();
            chk("stall.rstb", dom_rstb, 3'b011);
            chk("stall.cur", cur_dom, 3'd1);
        end
        dom_ready = 3'b110;
        tick();
        base = edge_n;
        advance_to(base + 7);
        chk("stall.pre", dom_rstb, 3'b011);
        tick();
        chk("stall.rel2", dom_rstb, 3'b111);
        tick();
        chk("stall.done", {2'b00, seq_done}, 3'b001);

        // Asynchronous board reset while waiting on domain 1.
        dom_ready = 3'b001;
        sw_pulse();
        base = edge_n;
        advance_to(base + 18);
        check_all("async.pre", 3'b011, 1'b0, 3'd1, 1'b0);
        #2;
        rstb_h = 1'b0;
        #1;
        check_all("async.now", 3'b000, 1'b0, 3'd0, 1'b0);
        tick();
        check_all("async.held", 3'b000, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rstb_h    = 1'b1;
        dom_ready = 3'b111;
        edge_n    = 0;
        run_table("seq3", 0);

        // Domain 0 never acknowledges.
        rstb_h = 1'b0;
        tick();
        dom_ready = 3'b110;
        @(negedge clk);
        rstb_h = 1'b1;
        edge_n = 0;
        advance_to(9);
        check_all("wdt.rel0", 3'b001, 1'b0, 3'd0, 1'b0);
`ifdef RST_SEQ_WDT_EN
        advance_to(23);
        check_all("wdt.pre", 3'b001, 1'b0, 3'd0, 1'b0);
        tick();
        check_all("wdt.to", 3'b001, 1'b0, 3'd1, 1'b1);
        sw_pulse();
        check_all("wdt.sticky", 3'b000, 1'b0, 3'd0, 1'b1);
`else
        for (int n = 0; n < 40; n++) begin
            tick();
            chk("nowdt.rstb", dom_rstb, 3'b001);
            chk("nowdt.cur", cur_dom, 3'd0);
            chk("nowdt.err", {2'b00, seq_err}, 3'b000);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
